// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
// Holds the store funct3 encodings and the packed buffer-entry layout.
// Imported by the top and the alignment sub-module.
package store_buffer_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // One buffered write: word address, lane-aligned data, byte enables.
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/stbuf_align.sv
// Store alignment and legality check: builds a lane-aligned buffer entry.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is used.
module stbuf_align
    import store_buffer_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output sb_entry_t   entry,
    output logic        illegal
);

    // Replicate the store data across lanes and select the byte enables.
    always_comb begin
        entry      = '0;
        illegal    = 1'b0;
        entry.addr = addr[31:2];
        case (funct3)
            F3_SB: begin
                entry.wdata = {4{data[7:0]}};
                entry.be    = 4'b0001 << addr[1:0];
            end
            F3_SH: begin
                entry.wdata = {2{data[15:0]}};
                entry.be    = addr[1] ? 4'b1100 : 4'b0011;
                illegal     = addr[0];
            end
            F3_SW: begin
                entry.wdata = data;
                entry.be    = 4'b1111;
                illegal     = (addr[1:0] != 2'b00);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of aligned stores draining to memory, with load hazard check.
// Latency: an accepted store is presented on mem_valid one cycle later.
// Backpressure: st_ready drops when full; head holds while mem_ready is low.
// STBUF_LD_MATCH_EN: when defined, ld_hazard compares word addresses of valid
// entries; otherwise any buffered store stalls a load.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [2:0]               st_funct3,
    output logic                     st_err,
    output logic [31:0]              st_err_addr,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     ld_check,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t         entries [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              head_vld;
    sb_entry_t         st_entry;
    logic              st_illegal;
    logic              full;
    logic              st_fire;
    logic              push;
    logic              pop;
    sb_entry_t         head;

    stbuf_align u_align (
        .addr    (st_addr),
        .data    (st_data),
        .funct3  (st_funct3),
        .entry   (st_entry),
        .illegal (st_illegal)
    );

    // A pop never frees a slot for a push in the same cycle when full.
    assign full     = (cnt == CW'(DEPTH));
    assign st_ready = !full;
    assign st_fire  = st_valid && st_ready;
    assign push     = st_fire && !st_illegal;
    assign pop      = head_vld && mem_ready;

    // Occupancy after this edge's push/pop.
    always_comb begin
        cnt_next = cnt;
        case ({push, pop})
            2'b10:   cnt_next = cnt + CW'(1);
            2'b01:   cnt_next = cnt - CW'(1);
            default: cnt_next = cnt;
        endcase
    end

    // Pointers, occupancy and the registered head-valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            head_vld <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt      <= cnt_next;
            head_vld <= (cnt_next != '0);
        end
    end

    // Entry storage; contents are only meaningful inside the valid window.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= st_entry;
    end

    // Rejected stores raise a one-cycle error and record their address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_err      <= 1'b0;
            st_err_addr <= '0;
        end else begin
            st_err <= st_fire && st_illegal;
            if (st_fire && st_illegal) st_err_addr <= st_addr;
        end
    end

    assign head      = entries[rd_ptr];
    assign mem_valid = head_vld;
    assign mem_addr  = head_vld ? {head.addr, 2'b00} : '0;
    assign mem_wdata = head_vld ? head.wdata : '0;
    assign mem_be    = head_vld ? head.be : '0;
    assign empty     = (cnt == '0);
    assign count     = cnt;

`ifdef STBUF_LD_MATCH_EN
    logic ld_hit;

    // Match the load word against every entry inside the valid window.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(PW'(i) - rd_ptr) < cnt) && (entries[i].addr == ld_addr[31:2]))
                ld_hit = 1'b1;
        end
    end

    assign ld_hazard = ld_check && ld_hit;
`else
    logic ld_addr_unused;

    assign ld_addr_unused = &{1'b0, ld_addr};
    assign ld_hazard      = ld_check && !empty;
`endif

endmodule
